// File: rtl/capture_sequencer.sv
// Frame capture sequencer: paces ADC sampling by decimation factor n, fills the
// FFT input RAM, kicks the FFT and hands each finished frame to the display.
//
// state     | meaning
// IDLE      | stopped, waiting for run
// ARM       | latch n, clear write address and divider
// CAPTURE   | paced sampling into RAM, FRAME_LEN writes
// FFT_START | one-cycle FFT start pulse
// FFT_WAIT  | waiting for fft_done
// DISPLAY   | disp_req held until disp_ack
module capture_sequencer #(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int BASE_DIV  = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [7:0]        n,
  output logic              sample_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              disp_req,
  input  logic              disp_ack,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    FFT_START,
    FFT_WAIT,
    DISPLAY
  } state_t;

  state_t            state, state_d;
  logic [7:0]        n_q;
  logic [7:0]        n_eff;
  logic [BASE_W-1:0] base_cnt;
  logic [7:0]        decim_cnt;
  logic              base_tc;
  logic              decim_tc;
  logic              n_chg;
  logic              last_addr;

  always_comb begin
    n_eff     = (n == 8'd0) ? 8'd1 : n;
    n_chg     = (n_eff != n_q);
    base_tc   = (base_cnt == '0);
    decim_tc  = (decim_cnt == 8'd0);
    last_addr = (wr_addr == ADDR_W'(FRAME_LEN - 1));
    // stop and rate change both suppress a strobe landing in the same cycle
    sample_en = (state == CAPTURE) && base_tc && decim_tc && run && !n_chg;
    wr_en     = sample_en;
    fft_start = (state == FFT_START);
    busy      = (state != IDLE);
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (run) state_d = ARM;
      ARM:       state_d = run ? CAPTURE : IDLE;
      CAPTURE: begin
        if (!run)                        state_d = IDLE;
        else if (n_chg)                  state_d = ARM;
        else if (sample_en && last_addr) state_d = FFT_START;
      end
      FFT_START: state_d = FFT_WAIT;
      FFT_WAIT:  if (fft_done) state_d = DISPLAY;
      DISPLAY:   if (disp_ack) state_d = run ? ARM : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Divider is a pair of down-counters: base ticks at zero, decim counts base ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q       <= 8'd0;
      base_cnt  <= '0;
      decim_cnt <= 8'd0;
      wr_addr   <= '0;
      frame_cnt <= 16'd0;
      disp_req  <= 1'b0;
    end else begin
      disp_req <= (state_d == DISPLAY);
      case (state)
        ARM: begin
          n_q       <= n_eff;
          base_cnt  <= BASE_W'(BASE_DIV - 1);
          decim_cnt <= n_eff - 8'd1;
          wr_addr   <= '0;
        end
        CAPTURE: begin
          base_cnt <= base_tc ? BASE_W'(BASE_DIV - 1) : base_cnt - BASE_W'(1);
          if (base_tc)
            decim_cnt <= decim_tc ? n_q - 8'd1 : decim_cnt - 8'd1;
          if (sample_en)
            wr_addr <= wr_addr + ADDR_W'(1);
        end
        DISPLAY: begin
          if (disp_ack)
            frame_cnt <= frame_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer with a small frame and fast base tick;
// a cycle-level reference model plus directed timing checks.
module tb_capture_sequencer;

  localparam int FL = 8;
  localparam int AW = 3;
  localparam int BD = 4;

  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_CAP  = 2;
  localparam int P_FST  = 3;
  localparam int P_FWT  = 4;
  localparam int P_DISP = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [7:0]    n;
  logic          sample_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          fft_start;
  logic          fft_done;
  logic          disp_req;
  logic          disp_ack;
  logic          busy;
  logic [15:0]   frame_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int strobe_t[$];
  int addr_q[$];
  int fs_t[$];

  int m_phase;
  int m_nq;
  int m_k;
  int m_frames;

  capture_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW), .BASE_DIV(BD)) dut (
    .clk(clk), .rst(rst), .run(run), .n(n),
    .sample_en(sample_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .fft_start(fft_start), .fft_done(fft_done),
    .disp_req(disp_req), .disp_ack(disp_ack),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = fft_start, 1 = disp_req, 2 = sample_en
  task automatic wait_for(input int sel, input int limit, input string name);
    int  w    = 0;
    bit  seen = 1'b0;
    while (!seen && w < limit) begin
      @(negedge clk);
      seen = (sel == 0) ? fft_start : (sel == 1) ? disp_req : sample_en;
      w++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: timeout after %0d cycles waiting for event", name, limit);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    strobe_t.delete();
    addr_q.delete();
    fs_t.delete();
  endtask

  // Reference model: capture timing derived from elapsed cycles since capture start.
  always @(negedge clk) begin : cmp
    int neff;
    int per;
    int done_w;
    bit strobe;
    if (!rst) begin
      m_phase  = P_IDLE;
      m_frames = 0;
      m_k      = 0;
      m_nq     = 1;
      chk("rst_busy", busy, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_sample_en", sample_en, 0);
      chk("rst_fft_start", fft_start, 0);
      chk("rst_disp_req", disp_req, 0);
    end else begin
      neff   = (n == 8'd0) ? 1 : int'(n);
      strobe = 1'b0;
      done_w = 0;
      if (m_phase == P_CAP) begin
        per    = BD * m_nq;
        done_w = m_k / per;
        strobe = (((m_k + 1) % per) == 0) && run && (neff == m_nq);
        chk("wr_addr", wr_addr, done_w % FL);
      end
      chk("sample_en", sample_en, strobe);
      chk("wr_en", wr_en, strobe);
      chk("busy", busy, m_phase != P_IDLE);
      chk("fft_start", fft_start, m_phase == P_FST);
      chk("disp_req", disp_req, m_phase == P_DISP);
      chk("frame_cnt", frame_cnt, m_frames % 65536);
      if (m_phase == P_FST) chk("wr_addr_wrap", wr_addr, 0);
      if (sample_en) begin
        strobe_t.push_back(cyc);
        addr_q.push_back(int'(wr_addr));
      end
      if (fft_start) fs_t.push_back(cyc);
      case (m_phase)
        P_IDLE: if (run) m_phase = P_ARM;
        P_ARM: begin
          if (!run) m_phase = P_IDLE;
          else begin
            m_nq = neff;
            m_k = 0;
            m_phase = P_CAP;
          end
        end
        P_CAP: begin
          if (!run)                              m_phase = P_IDLE;
          else if (neff != m_nq)                 m_phase = P_ARM;
          else if (strobe && done_w == FL - 1)   m_phase = P_FST;
          else                                   m_k = m_k + 1;
        end
        P_FST: m_phase = P_FWT;
        P_FWT: if (fft_done) m_phase = P_DISP;
        P_DISP: begin
          if (disp_ack) begin
            m_frames = m_frames + 1;
            m_phase = run ? P_ARM : P_IDLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  initial begin
    int t_run;
    int f_t;
    rst = 1'b0; run = 1'b0; n = 8'd1; fft_done = 1'b0; disp_ack = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();

    // n=1: first strobe 4 cycles into CAPTURE, period 4, addresses 0..7
    clear_q();
    run = 1'b1; n = 8'd1; t_run = cyc;
    wait_for(0, 100, "t1_fft_start");
    chk("t1_strobes", strobe_t.size(), 8);
    if (strobe_t.size() == 8 && fs_t.size() == 1) begin
      chk("t1_first_strobe", strobe_t[0] - t_run, 5);
      for (int i = 1; i < 8; i++) chk("t1_period", strobe_t[i] - strobe_t[i-1], 4);
      for (int i = 0; i < 8; i++) chk("t1_addr", addr_q[i], i);
      chk("t1_fft_after_last", fs_t[0] - strobe_t[7], 1);
    end
    f_t = cyc - 1;

    // fft_done 30 cycles after fft_start, ack 3 cycles after disp_req
    repeat (29) step();
    chk("t3_fft_done_gap", cyc - f_t, 30);
    chk("t3_req_low", disp_req, 0);
    fft_done = 1'b1; step(); fft_done = 1'b0;
    chk("t3_req_high", disp_req, 1);
    repeat (2) step();
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("t3_frame_cnt", frame_cnt, 1);
    chk("t3_rearm_busy", busy, 1);

    // n=5: period 20
    clear_q();
    n = 8'd5;
    wait_for(0, 400, "t2_fft_start_n5");
    chk("t2_strobes_n5", strobe_t.size(), 8);
    if (strobe_t.size() == 8)
      for (int i = 1; i < 8; i++) chk("t2_period_n5", strobe_t[i] - strobe_t[i-1], 20);
    fft_done = 1'b1; step(); fft_done = 1'b0;
    clear_q();
    n = 8'd0; disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("t2_frame_cnt", frame_cnt, 2);

    // n=0 behaves as 1; spurious fft_done during CAPTURE is ignored
    repeat (6) step();
    fft_done = 1'b1; step(); fft_done = 1'b0;
    chk("t6_spurious_busy", busy, 1);
    wait_for(0, 100, "t2_fft_start_n0");
    chk("t2_strobes_n0", strobe_t.size(), 8);
    if (strobe_t.size() == 8)
      for (int i = 1; i < 8; i++) chk("t2_period_n0", strobe_t[i] - strobe_t[i-1], 4);

    // run drops in FFT_WAIT: frame completes, then IDLE
    run = 1'b0;
    repeat (5) step();
    chk("t5_wait_busy", busy, 1);
    fft_done = 1'b1; step(); fft_done = 1'b0;
    chk("t5_req", disp_req, 1);
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("t5_idle_busy", busy, 0);
    chk("t5_frame_cnt", frame_cnt, 3);

    // n 2->4 after 3rd write aborts the frame and restarts at address 0
    clear_q();
    n = 8'd2; run = 1'b1;
    repeat (3) wait_for(2, 40, "t4_strobe");
    n = 8'd4;
    wait_for(0, 400, "t4_fft_start");
    chk("t4_strobes", strobe_t.size(), 11);
    chk("t4_fft_count", fs_t.size(), 1);
    if (strobe_t.size() == 11) begin
      for (int i = 1; i < 3; i++) chk("t4_period_n2", strobe_t[i] - strobe_t[i-1], 8);
      chk("t4_restart_gap", strobe_t[3] - strobe_t[2], 18);
      for (int i = 4; i < 11; i++) chk("t4_period_n4", strobe_t[i] - strobe_t[i-1], 16);
      for (int i = 3; i < 11; i++) chk("t4_addr", addr_q[i], i - 3);
    end
    fft_done = 1'b1; step(); fft_done = 1'b0;
    disp_ack = 1'b1; step(); disp_ack = 1'b0;
    chk("t4_frame_cnt", frame_cnt, 4);

    // run drops during CAPTURE: IDLE next cycle, no further strobes
    clear_q();
    repeat (2) wait_for(2, 40, "t5_strobe");
    run = 1'b0;
    step();
    chk("t5_cap_stop_busy", busy, 0);
    repeat (40) step();
    chk("t5_no_more_strobes", strobe_t.size(), 2);

    // async reset mid FFT_WAIT
    run = 1'b1; n = 8'd1;
    wait_for(0, 100, "t6_fft_start");
    repeat (3) step();
    chk("t6_pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_frame_cnt", frame_cnt, 0);
    chk("t6_rst_wr_addr", wr_addr, 0);
    chk("t6_rst_disp_req", disp_req, 0);
    run = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
